// File: rtl/simon_pkg.sv
// Shared Simon types and defaults, used by the sequence generator, the
// player checker and the LED driver.
//   colour_t            : 2-bit colour code
//   simon_chk_state_t   : player-check FSM states
//   simon_chk_flags_t   : registered single-bit status outputs of the checker
//   DEF_MAX_LEN         : default sequence buffer depth
//   DEF_TIMEOUT_CYCLES  : default idle cycles allowed between player presses
package simon_pkg;

   localparam int unsigned DEF_MAX_LEN        = 32;
   localparam int unsigned DEF_TIMEOUT_CYCLES = 50_000_000;

   typedef logic [1:0] colour_t;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RECORD = 2'd1,
      ST_PLAYER = 2'd2,
      ST_FAIL   = 2'd3
   } simon_chk_state_t;

   typedef struct packed {
      logic player_turn;
      logic match;
      logic round_pass;
      logic fail;
      logic timed_out;
      logic overflow;
   } simon_chk_flags_t;

endpackage

// File: rtl/simon_player_checker_if.sv
// Bus between the Simon generator / player input side and the player checker.
//   master : drives Simon colours/strobes and player presses, observes results
//   slave  : the checker; consumes strobes, drives turn/pulse/status outputs
//   seqLen / progress are LEN_W wide and must match the checker's LEN_W.
interface simon_player_checker_if
   import simon_pkg::*;
#(
   parameter int unsigned LEN_W = $clog2(DEF_MAX_LEN + 1)
) ();

   logic             simonTurn;
   colour_t          simonNum;
   logic             simonPressed;
   colour_t          playerNum;
   logic             playerPressed;

   logic             playerTurn;
   logic             match;
   logic             roundPass;
   logic             fail;
   logic             timedOut;
   logic             overflow;
   logic [LEN_W-1:0] seqLen;
   logic [LEN_W-1:0] progress;

   modport master (
      output simonTurn, simonNum, simonPressed, playerNum, playerPressed,
      input  playerTurn, match, roundPass, fail, timedOut, overflow, seqLen, progress
   );

   modport slave (
      input  simonTurn, simonNum, simonPressed, playerNum, playerPressed,
      output playerTurn, match, roundPass, fail, timedOut, overflow, seqLen, progress
   );

endinterface

// File: rtl/simon_seq_mem.sv
// MAX_LEN x colour register file holding the recorded Simon sequence.
//   clk       : write clock
//   wr_en     : write strobe, wr_data stored at wr_addr on the rising edge
//   wr_addr   : write index (LEN_W bits; out-of-range writes are dropped)
//   wr_data   : colour to store
//   rd_addr   : asynchronous read index
//   rd_data_c : combinational read data (0 for out-of-range index)
// Contents are deliberately not reset; the owner tracks validity by length.
module simon_seq_mem
   import simon_pkg::*;
#(
   parameter int unsigned MAX_LEN = DEF_MAX_LEN,
   parameter int unsigned LEN_W   = $clog2(MAX_LEN + 1)
) (
   input  logic             clk,
   input  logic             wr_en,
   input  logic [LEN_W-1:0] wr_addr,
   input  colour_t          wr_data,
   input  logic [LEN_W-1:0] rd_addr,
   output colour_t          rd_data_c
);

   localparam int unsigned IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
   localparam logic [LEN_W-1:0] DEPTH_V = LEN_W'(MAX_LEN);

   colour_t mem_q [MAX_LEN];

   // Storage only: no reset, so a new round or reset leaves old entries in place.
   always_ff @(posedge clk) begin
      if (wr_en && (wr_addr < DEPTH_V)) begin
         mem_q[wr_addr[IDX_W-1:0]] <= wr_data;
      end
   end

   // Asynchronous read so a compare sees the entry in the same cycle.
   always_comb begin
      rd_data_c = '0;
      if (rd_addr < DEPTH_V) begin
         rd_data_c = mem_q[rd_addr[IDX_W-1:0]];
      end
   end

endmodule

// File: rtl/simon_player_checker.sv
// Player-side checker: records the colours Simon emits while simonTurn is high,
// then checks each player press against the recorded sequence.
//   clk, rst_n           : clock, asynchronous active-low reset
//   bus (slave modport)  : Simon/player strobes in; playerTurn, match,
//                          roundPass, fail pulses, sticky timedOut/overflow,
//                          seqLen and progress counters out (all registered)
module simon_player_checker
   import simon_pkg::*;
#(
   parameter int unsigned MAX_LEN        = DEF_MAX_LEN,
   parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
   parameter int unsigned LEN_W          = $clog2(MAX_LEN + 1)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   simon_player_checker_if.slave  bus
);

   localparam int unsigned TMR_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam int unsigned TMR_MAX = (TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0;
   localparam bit          TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
   localparam logic [LEN_W-1:0] MAX_LEN_V = LEN_W'(MAX_LEN);
   localparam logic [TMR_W-1:0] TMR_MAX_V = TMR_W'(TMR_MAX);

   simon_chk_state_t state_q, state_d;
   simon_chk_flags_t flags_q, flags_d;
   logic [LEN_W-1:0] seq_len_q, seq_len_d;
   logic [LEN_W-1:0] progress_q, progress_d;
   logic [TMR_W-1:0] timer_q, timer_d;

   logic             wr_en_c;
   logic [LEN_W-1:0] wr_addr_c;
   colour_t          rd_data_c;
   logic [LEN_W-1:0] progress_inc_c;
   logic             start_round_c;

   simon_seq_mem #(
      .MAX_LEN (MAX_LEN),
      .LEN_W   (LEN_W)
   ) u_seq_mem (
      .clk       (clk),
      .wr_en     (wr_en_c),
      .wr_addr   (wr_addr_c),
      .wr_data   (bus.simonNum),
      .rd_addr   (progress_q),
      .rd_data_c (rd_data_c)
   );

   assign progress_inc_c = progress_q + LEN_W'(1);

   // simonTurn seen high from any state other than RECORD opens a fresh round.
   assign start_round_c = bus.simonTurn && (state_q != ST_RECORD);

   // Next-state, counters, memory write and output pulses.
   always_comb begin
      state_d          = state_q;
      seq_len_d        = seq_len_q;
      progress_d       = progress_q;
      timer_d          = timer_q;
      flags_d          = flags_q;
      flags_d.match      = 1'b0;
      flags_d.round_pass = 1'b0;
      flags_d.fail       = 1'b0;
      wr_en_c          = 1'b0;
      wr_addr_c        = seq_len_q;

      case (state_q)
         ST_RECORD: begin
            if (bus.simonTurn) begin
               if (bus.simonPressed) begin
                  if (seq_len_q < MAX_LEN_V) begin
                     wr_en_c   = 1'b1;
                     seq_len_d = seq_len_q + LEN_W'(1);
                  end else begin
                     flags_d.overflow = 1'b1;
                  end
               end
            end else if (seq_len_q == '0) begin
               state_d = ST_IDLE;
            end else begin
               state_d    = ST_PLAYER;
               progress_d = '0;
               timer_d    = '0;
            end
         end

         ST_PLAYER: begin
            // A rising simonTurn aborts silently; handled by start_round_c below.
            if (!bus.simonTurn) begin
               if (bus.playerPressed) begin
                  // A press in the timeout cycle still counts and restarts the timer.
                  timer_d = '0;
                  if (bus.playerNum == rd_data_c) begin
                     flags_d.match = 1'b1;
                     progress_d    = progress_inc_c;
                     if (progress_inc_c == seq_len_q) begin
                        flags_d.round_pass = 1'b1;
                        state_d            = ST_IDLE;
                     end
                  end else begin
                     flags_d.fail = 1'b1;
                     state_d      = ST_FAIL;
                  end
               end else if (TIMEOUT_EN && (timer_q == TMR_MAX_V)) begin
                  flags_d.fail      = 1'b1;
                  flags_d.timed_out = 1'b1;
                  state_d           = ST_FAIL;
               end else if (TIMEOUT_EN) begin
                  timer_d = timer_q + TMR_W'(1);
               end
            end
         end

         default: begin
            // IDLE and FAIL hold until start_round_c.
         end
      endcase

      // Fresh round: clear counters and sticky flags; a strobe in the rising
      // cycle is recorded as entry 0.
      if (start_round_c) begin
         state_d           = ST_RECORD;
         seq_len_d         = '0;
         progress_d        = '0;
         timer_d           = '0;
         flags_d.overflow  = 1'b0;
         flags_d.timed_out = 1'b0;
         if (bus.simonPressed) begin
            wr_en_c   = 1'b1;
            wr_addr_c = '0;
            seq_len_d = LEN_W'(1);
         end
      end

      flags_d.player_turn = (state_d == ST_PLAYER);
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         flags_q    <= '0;
         seq_len_q  <= '0;
         progress_q <= '0;
         timer_q    <= '0;
      end else begin
         state_q    <= state_d;
         flags_q    <= flags_d;
         seq_len_q  <= seq_len_d;
         progress_q <= progress_d;
         timer_q    <= timer_d;
      end
   end

   assign bus.playerTurn = flags_q.player_turn;
   assign bus.match      = flags_q.match;
   assign bus.roundPass  = flags_q.round_pass;
   assign bus.fail       = flags_q.fail;
   assign bus.timedOut   = flags_q.timed_out;
   assign bus.overflow   = flags_q.overflow;
   assign bus.seqLen     = seq_len_q;
   assign bus.progress   = progress_q;

endmodule

// File: tb/tb_simon_player_checker.sv
// Self-checking bench for simon_player_checker (MAX_LEN=4, TIMEOUT_CYCLES=10).
// Inputs change after the falling edge; outputs are compared at the next
// falling edge against a queue-based model of the game rules.
module tb_simon_player_checker;
   import simon_pkg::*;

   localparam int unsigned MAX_LEN = 4;
   localparam int unsigned TMO     = 10;
   localparam int unsigned LEN_W   = 3;

   logic clk;
   logic rst_n;

   simon_player_checker_if #(.LEN_W(LEN_W)) bus_if ();

   simon_player_checker #(
      .MAX_LEN        (MAX_LEN),
      .TIMEOUT_CYCLES (TMO),
      .LEN_W          (LEN_W)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_if)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int total = 0;
   int bad   = 0;

   // Model state: expected levels/counters and the valid recorded colours.
   logic    e_pt, e_to, e_ov;
   int      e_len, e_prog;
   colour_t m_buf[$];
   colour_t stim_q[$];
   colour_t press_q[$];
   int      gap_q[$];
   int      outcome;   // 0 still playing, 1 passed, 2 failed

   logic [11:0] obs, expv;

   function automatic logic [11:0] observe();
      return {bus_if.playerTurn, bus_if.match, bus_if.roundPass, bus_if.fail,
              bus_if.timedOut, bus_if.overflow, bus_if.seqLen, bus_if.progress};
   endfunction

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic clear_inputs();
      bus_if.simonTurn     = 1'b0;
      bus_if.simonNum      = '0;
      bus_if.simonPressed  = 1'b0;
      bus_if.playerNum     = '0;
      bus_if.playerPressed = 1'b0;
   endtask

   // Record stim_q as one Simon round, optionally strobing in the rising cycle.
   task automatic record_seq(input string tag, input bit rise_press);
      logic rp;
      rp = rise_press && (stim_q.size() > 0);
      m_buf.delete();
      bus_if.simonTurn     = 1'b1;
      bus_if.simonPressed  = rp;
      bus_if.simonNum      = rp ? stim_q[0] : colour_t'($urandom_range(0, 3));
      bus_if.playerPressed = 1'b0;
      tick();
      if (rp) m_buf.push_back(stim_q[0]);
      e_pt = 1'b0; e_to = 1'b0; e_ov = 1'b0; e_prog = 0; e_len = m_buf.size();
      obs  = observe();
      expv = {e_pt, 1'b0, 1'b0, 1'b0, e_to, e_ov, LEN_W'(e_len), LEN_W'(e_prog)};
      total++;
      if (obs !== expv) begin
         bad++;
         $display("FAIL %s/enter: got flags=%b len=%0d prog=%0d, want flags=%b len=%0d prog=%0d",
                  tag, obs[11:6], obs[5:3], obs[2:0], expv[11:6], expv[5:3], expv[2:0]);
      end
      for (int i = (rp ? 1 : 0); i < stim_q.size(); i++) begin
         bus_if.simonPressed  = 1'b1;
         bus_if.simonNum      = stim_q[i];
         bus_if.playerPressed = 1'($urandom_range(0, 1));
         bus_if.playerNum     = colour_t'($urandom_range(0, 3));
         tick();
         if (m_buf.size() < MAX_LEN) m_buf.push_back(stim_q[i]);
         else e_ov = 1'b1;
         e_len = m_buf.size();
         obs  = observe();
         expv = {e_pt, 1'b0, 1'b0, 1'b0, e_to, e_ov, LEN_W'(e_len), LEN_W'(e_prog)};
         total++;
         if (obs !== expv) begin
            bad++;
            $display("FAIL %s/rec%0d: got flags=%b len=%0d prog=%0d, want flags=%b len=%0d prog=%0d",
                     tag, i, obs[11:6], obs[5:3], obs[2:0], expv[11:6], expv[5:3], expv[2:0]);
         end
         bus_if.simonPressed  = 1'b0;
         bus_if.playerPressed = 1'b0;
         tick();
      end
      bus_if.simonTurn     = 1'b0;
      bus_if.simonPressed  = 1'b0;
      bus_if.playerPressed = 1'b0;
      tick();
      e_pt = (e_len > 0);
      obs  = observe();
      expv = {e_pt, 1'b0, 1'b0, 1'b0, e_to, e_ov, LEN_W'(e_len), LEN_W'(e_prog)};
      total++;
      if (obs !== expv) begin
         bad++;
         $display("FAIL %s/fall: got flags=%b len=%0d prog=%0d, want flags=%b len=%0d prog=%0d",
                  tag, obs[11:6], obs[5:3], obs[2:0], expv[11:6], expv[5:3], expv[2:0]);
      end
   endtask

   // Play press_q with idle gaps gap_q; a run of TMO idle cycles is a timeout.
   task automatic play_round(input string tag);
      int   idle;
      logic m, r, f;
      idle    = 0;
      outcome = 0;
      for (int i = 0; i < press_q.size() && outcome == 0; i++) begin
         for (int k = 0; k < gap_q[i] && outcome == 0; k++) begin
            bus_if.playerPressed = 1'b0;
            bus_if.playerNum     = colour_t'($urandom_range(0, 3));
            tick();
            idle++;
            f = 1'b0;
            if (idle == TMO) begin
               f = 1'b1; e_to = 1'b1; e_pt = 1'b0; outcome = 2;
            end
            obs  = observe();
            expv = {e_pt, 1'b0, 1'b0, f, e_to, e_ov, LEN_W'(e_len), LEN_W'(e_prog)};
            total++;
            if (obs !== expv) begin
               bad++;
               $display("FAIL %s/idle%0d.%0d: got flags=%b len=%0d prog=%0d, want flags=%b len=%0d prog=%0d",
                        tag, i, k, obs[11:6], obs[5:3], obs[2:0], expv[11:6], expv[5:3], expv[2:0]);
            end
         end
         if (outcome == 0) begin
            bus_if.playerPressed = 1'b1;
            bus_if.playerNum     = press_q[i];
            tick();
            idle = 0;
            m = 1'b0; r = 1'b0; f = 1'b0;
            if (press_q[i] == m_buf[e_prog]) begin
               m = 1'b1;
               e_prog++;
               if (e_prog == e_len) begin
                  r = 1'b1; e_pt = 1'b0; outcome = 1;
               end
            end else begin
               f = 1'b1; e_pt = 1'b0; outcome = 2;
            end
            obs  = observe();
            expv = {e_pt, m, r, f, e_to, e_ov, LEN_W'(e_len), LEN_W'(e_prog)};
            total++;
            if (obs !== expv) begin
               bad++;
               $display("FAIL %s/press%0d: got flags=%b len=%0d prog=%0d, want flags=%b len=%0d prog=%0d",
                        tag, i, obs[11:6], obs[5:3], obs[2:0], expv[11:6], expv[5:3], expv[2:0]);
            end
         end
      end
      bus_if.playerPressed = 1'b0;
   endtask

   // Idle cycles with stray strobes; nothing may change.
   task automatic test_quiet(input string tag, input int n);
      for (int i = 0; i < n; i++) begin
         bus_if.simonTurn     = 1'b0;
         bus_if.simonPressed  = 1'($urandom_range(0, 1));
         bus_if.simonNum      = colour_t'($urandom_range(0, 3));
         bus_if.playerPressed = 1'($urandom_range(0, 1));
         bus_if.playerNum     = colour_t'($urandom_range(0, 3));
         tick();
         obs  = observe();
         expv = {e_pt, 1'b0, 1'b0, 1'b0, e_to, e_ov, LEN_W'(e_len), LEN_W'(e_prog)};
         total++;
         if (obs !== expv) begin
            bad++;
            $display("FAIL %s/quiet%0d: got flags=%b len=%0d prog=%0d, want flags=%b len=%0d prog=%0d",
                     tag, i, obs[11:6], obs[5:3], obs[2:0], expv[11:6], expv[5:3], expv[2:0]);
         end
      end
      clear_inputs();
   endtask

   task automatic test_reset();
      clear_inputs();
      rst_n = 1'b0;
      e_pt = 1'b0; e_to = 1'b0; e_ov = 1'b0; e_len = 0; e_prog = 0;
      @(negedge clk);
      obs = observe();
      total++;
      if (obs !== 12'd0) begin
         bad++;
         $display("FAIL reset: got %b want %b", obs, 12'd0);
      end
      rst_n = 1'b1;
      test_quiet("reset_release", 3);
   endtask

   task automatic test_basic();
      stim_q = '{2'd2, 2'd0, 2'd3};
      record_seq("basic", 1'b0);
      press_q = '{2'd2, 2'd0, 2'd3};
      gap_q   = '{0, 0, 0};
      play_round("basic");
      test_quiet("basic_after", 2);
   endtask

   task automatic test_wrong();
      stim_q = '{2'd1, 2'd1};
      record_seq("wrong", 1'b0);
      press_q = '{2'd1, 2'd2};
      gap_q   = '{1, 2};
      play_round("wrong");
      test_quiet("wrong_hold", 3);
      stim_q = '{};
      record_seq("wrong_restart", 1'b0);
   endtask

   task automatic test_timeout();
      stim_q = '{2'd3};
      record_seq("tmo", 1'b0);
      press_q = '{2'd3};
      gap_q   = '{TMO + 2};
      play_round("tmo");
      test_quiet("tmo_hold", 2);
      stim_q = '{2'd3, 2'd1};
      record_seq("tmo_edge", 1'b0);
      press_q = '{2'd3, 2'd1};
      gap_q   = '{TMO - 1, TMO - 1};
      play_round("tmo_edge");
   endtask

   task automatic test_overflow();
      stim_q = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd1};
      record_seq("ovf", 1'b1);
      press_q = '{2'd0, 2'd1, 2'd2, 2'd3};
      gap_q   = '{0, 1, 0, 2};
      play_round("ovf");
      test_quiet("ovf_after", 2);
   endtask

   task automatic test_empty_and_abort();
      stim_q = '{};
      record_seq("empty", 1'b0);
      test_quiet("empty_idle", 4);
      stim_q = '{2'd1, 2'd3, 2'd2};
      record_seq("abort", 1'b0);
      press_q = '{2'd1};
      gap_q   = '{0};
      play_round("abort");
      stim_q = '{2'd0, 2'd2};
      record_seq("abort_new", 1'b1);
      press_q = '{2'd0, 2'd2};
      gap_q   = '{0, 0};
      play_round("abort_new");
   endtask

   task automatic test_reset_mid();
      stim_q = '{2'd2, 2'd1, 2'd0};
      record_seq("rstmid", 1'b0);
      press_q = '{2'd2, 2'd1};
      gap_q   = '{0, 0};
      play_round("rstmid");
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      obs = observe();
      total++;
      if (obs !== 12'd0) begin
         bad++;
         $display("FAIL rstmid/async: got %b want %b", obs, 12'd0);
      end
      e_pt = 1'b0; e_to = 1'b0; e_ov = 1'b0; e_len = 0; e_prog = 0;
      @(negedge clk);
      rst_n = 1'b1;
      test_quiet("rstmid_release", 3);
   endtask

   task automatic test_random();
      int n;
      for (int rnd = 0; rnd < 25; rnd++) begin
         n = $urandom_range(1, 6);
         stim_q = '{};
         for (int i = 0; i < n; i++) stim_q.push_back(colour_t'($urandom_range(0, 3)));
         record_seq("rand", 1'($urandom_range(0, 1)));
         press_q = '{};
         gap_q   = '{};
         for (int i = 0; i < e_len; i++) begin
            if ($urandom_range(0, 9) == 0)
               press_q.push_back(m_buf[i] ^ colour_t'($urandom_range(1, 3)));
            else
               press_q.push_back(m_buf[i]);
            if ($urandom_range(0, 14) == 0) gap_q.push_back(int'($urandom_range(TMO, TMO + 2)));
            else gap_q.push_back(int'($urandom_range(0, 3)));
         end
         play_round("rand");
         test_quiet("rand_after", 1);
      end
   endtask

   initial begin
      clear_inputs();
      rst_n = 1'b0;
      test_reset();
      test_basic();
      test_wrong();
      test_timeout();
      test_overflow();
      test_empty_and_abort();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
